hazard_scoreboard: RTL and testbench

- Parametrised successor to the decode-stall/branch-discard hazard unit of the ECAP5-DPROC pipeline.
- Replaces per-stage address comparison with a per-register pending-write scoreboard, so the tracked pipeline depth is a parameter.
- Adds a multi-cycle branch-discard window that also cancels the scoreboard entry of a killed execute-stage write.
- Adds a sticky error flag for scoreboard inconsistency.

---
 rtl/hazard_scoreboard.sv | 132 +++++++++++++
 tb/tb_hazard_scoreboard.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_scoreboard.sv
// Decode-stall / branch-discard hazard unit built around a per-register pending-write scoreboard.
// Optional macro HAZARD_SCOREBOARD_STATS_EN adds saturating stall/discard activity counters.
module hazard_scoreboard #(
  parameter int NB_INFLIGHT    = 3,
  parameter int NB_REGS        = 32,
  parameter int ADDR_W         = 5,
  parameter int DISCARD_CYCLES = 2
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              branch_i,
  output logic              ex_discard_request_o,
  input  logic              dec_valid_i,
  input  logic [ADDR_W-1:0] reg_raddr1_i,
  input  logic [ADDR_W-1:0] reg_raddr2_i,
  input  logic              dec_reg_write_i,
  input  logic [ADDR_W-1:0] dec_reg_addr_i,
  input  logic              ex_reg_write_i,
  input  logic [ADDR_W-1:0] ex_reg_addr_i,
  input  logic              reg_write_i,
  input  logic [ADDR_W-1:0] reg_waddr_i,
  output logic              dec_stall_request_o,
  output logic              err_o
`ifdef HAZARD_SCOREBOARD_STATS_EN
  ,
  output logic [31:0]       stall_count_o,
  output logic [31:0]       discard_count_o
`endif
);

  localparam int CW = $clog2(NB_INFLIGHT + 1);
  localparam int DW = $clog2(DISCARD_CYCLES + 1);
  localparam int NW = CW + 2;

  logic [CW-1:0] pending_q [NB_REGS];
  logic [CW-1:0] pending_d [NB_REGS];
  logic [DW-1:0] dcnt_q;
  logic          discard_q;
  logic          first_q;
  logic          err_q;

  logic srcHazard1;
  logic srcHazard2;
  logic destFull;
  logic stallReq;
  logic issueEn;
  logic retireEn;
  logic cancelEn;
  logic errSet;

  assign srcHazard1 = (reg_raddr1_i != '0) && (pending_q[reg_raddr1_i] != '0);
  assign srcHazard2 = (reg_raddr2_i != '0) && (pending_q[reg_raddr2_i] != '0);
  assign destFull   = dec_reg_write_i && (pending_q[dec_reg_addr_i] == CW'(NB_INFLIGHT));
  assign stallReq   = (dec_valid_i && (srcHazard1 || srcHazard2)) || destFull;

  assign issueEn  = dec_valid_i && dec_reg_write_i && (dec_reg_addr_i != '0)
                    && !stallReq && !discard_q;
  assign retireEn = reg_write_i && (reg_waddr_i != '0);
  // Only the instruction sitting in execute when the window opens gets killed.
  assign cancelEn = discard_q && first_q && ex_reg_write_i && (ex_reg_addr_i != '0);

  always_comb begin
    pending_d = pending_q;
    errSet    = 1'b0;
    pending_d[0] = '0;
    for (int r = 1; r < NB_REGS; r++) begin
      logic [NW-1:0] incV;
      logic [NW-1:0] decV;
      logic [NW-1:0] sumV;
      incV = NW'(issueEn && (dec_reg_addr_i == ADDR_W'(r)));
      decV = NW'(retireEn && (reg_waddr_i == ADDR_W'(r)))
           + NW'(cancelEn && (ex_reg_addr_i == ADDR_W'(r)));
      sumV = NW'(pending_q[r]) + incV;
      if (sumV < decV) begin
        pending_d[r] = '0;
        errSet       = 1'b1;
      end else if ((sumV - decV) > NW'(NB_INFLIGHT)) begin
        errSet = 1'b1;
      end else begin
        pending_d[r] = CW'(sumV - decV);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      for (int r = 0; r < NB_REGS; r++) pending_q[r] <= '0;
      dcnt_q    <= '0;
      discard_q <= 1'b0;
      first_q   <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      for (int r = 0; r < NB_REGS; r++) pending_q[r] <= pending_d[r];
      err_q   <= err_q | errSet;
      first_q <= branch_i && (dcnt_q == '0);
      if (branch_i) begin
        dcnt_q    <= DW'(DISCARD_CYCLES);
        discard_q <= 1'b1;
      end else if (dcnt_q != '0) begin
        dcnt_q    <= dcnt_q - DW'(1);
        discard_q <= (dcnt_q > DW'(1));
      end else begin
        discard_q <= 1'b0;
      end
    end
  end

  assign ex_discard_request_o = discard_q;
  assign dec_stall_request_o  = stallReq;
  assign err_o                = err_q;

`ifdef HAZARD_SCOREBOARD_STATS_EN
  logic [31:0] stallCnt_q;
  logic [31:0] discardCnt_q;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      stallCnt_q   <= '0;
      discardCnt_q <= '0;
    end else begin
      if (stallReq && (stallCnt_q != '1))
        stallCnt_q <= stallCnt_q + 32'd1;
      if (discard_q && (discardCnt_q != '1))
        discardCnt_q <= discardCnt_q + 32'd1;
    end
  end

  assign stall_count_o   = stallCnt_q;
  assign discard_count_o = discardCnt_q;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench for hazard_scoreboard: directed scenarios followed by random traffic,
// compared against a pending-count reference model.
module tb_hazard_scoreboard;

  localparam int NB_INFLIGHT    = 3;
  localparam int DISCARD_CYCLES = 2;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic       branch_i;
  logic       ex_discard_request_o;
  logic       dec_valid_i;
  logic [4:0] reg_raddr1_i;
  logic [4:0] reg_raddr2_i;
  logic       dec_reg_write_i;
  logic [4:0] dec_reg_addr_i;
  logic       ex_reg_write_i;
  logic [4:0] ex_reg_addr_i;
  logic       reg_write_i;
  logic [4:0] reg_waddr_i;
  logic       dec_stall_request_o;
  logic       err_o;
`ifdef HAZARD_SCOREBOARD_STATS_EN
  logic [31:0] stall_count_o;
  logic [31:0] discard_count_o;
`endif

  hazard_scoreboard dut (
    .clk_i                (clk_i),
    .rst_i                (rst_i),
    .branch_i             (branch_i),
    .ex_discard_request_o (ex_discard_request_o),
    .dec_valid_i          (dec_valid_i),
    .reg_raddr1_i         (reg_raddr1_i),
    .reg_raddr2_i         (reg_raddr2_i),
    .dec_reg_write_i      (dec_reg_write_i),
    .dec_reg_addr_i       (dec_reg_addr_i),
    .ex_reg_write_i       (ex_reg_write_i),
    .ex_reg_addr_i        (ex_reg_addr_i),
    .reg_write_i          (reg_write_i),
    .reg_waddr_i          (reg_waddr_i),
    .dec_stall_request_o  (dec_stall_request_o),
`ifdef HAZARD_SCOREBOARD_STATS_EN
    .stall_count_o        (stall_count_o),
    .discard_count_o      (discard_count_o),
`endif
    .err_o                (err_o)
  );

  always #5 clk_i = ~clk_i;

  int evals = 0;
  int fails = 0;

  // Reference model: outstanding writes per register, cycles left in the discard
  // window, whether this is the opening cycle of a window, and the sticky error.
  int          pend [32];
  int          windowLeft;
  bit          windowOpening;
  bit          errM;
  logic [31:0] statStall;
  logic [31:0] statDiscard;

  function automatic bit modelStall();
    bit hz;
    hz = (reg_raddr1_i != 0 && pend[reg_raddr1_i] != 0) ||
         (reg_raddr2_i != 0 && pend[reg_raddr2_i] != 0);
    return (dec_valid_i && hz) ||
           (dec_reg_write_i && pend[dec_reg_addr_i] == NB_INFLIGHT);
  endfunction

  task automatic modelReset();
    foreach (pend[r]) pend[r] = 0;
    windowLeft    = 0;
    windowOpening = 0;
    errM          = 0;
    statStall     = '0;
    statDiscard   = '0;
  endtask

  task automatic modelAdvance();
    bit st, dis, iss, can, ret;
    int n;
    st  = modelStall();
    dis = (windowLeft > 0);
    iss = dec_valid_i && dec_reg_write_i && dec_reg_addr_i != 0 && !st && !dis;
    can = dis && windowOpening && ex_reg_write_i && ex_reg_addr_i != 0;
    ret = reg_write_i && reg_waddr_i != 0;
    for (int r = 1; r < 32; r++) begin
      n = pend[r];
      if (iss && dec_reg_addr_i == r) n++;
      if (ret && reg_waddr_i == r) n--;
      if (can && ex_reg_addr_i == r) n--;
      if (n < 0) begin
        n = 0;
        errM = 1;
      end else if (n > NB_INFLIGHT) begin
        n = pend[r];
        errM = 1;
      end
      pend[r] = n;
    end
    if (st && statStall != 32'hFFFF_FFFF) statStall++;
    if (dis && statDiscard != 32'hFFFF_FFFF) statDiscard++;
    windowOpening = branch_i && (windowLeft == 0);
    if (branch_i) windowLeft = DISCARD_CYCLES;
    else if (windowLeft > 0) windowLeft--;
  endtask

  task automatic checkBit(input string tag, input logic obs, input logic exp);
    evals++;
    assert (obs === exp) else begin
      fails++;
      $error("[TB] FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic checkWord(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    evals++;
    assert (obs === exp) else begin
      fails++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic checkOutput(input string tag);
    checkBit({tag, "_stall"},   dec_stall_request_o,  modelStall());
    checkBit({tag, "_discard"}, ex_discard_request_o, windowLeft > 0);
    checkBit({tag, "_err"},     err_o,                errM);
`ifdef HAZARD_SCOREBOARD_STATS_EN
    checkWord({tag, "_stallcnt"},   stall_count_o,   statStall);
    checkWord({tag, "_discardcnt"}, discard_count_o, statDiscard);
`endif
  endtask

  task automatic applyStimulus(input bit br, input bit dv, input logic [4:0] r1,
                               input logic [4:0] r2, input bit dw, input logic [4:0] da,
                               input bit ew, input logic [4:0] ea, input bit rw,
                               input logic [4:0] wa);
    branch_i        = br;
    dec_valid_i     = dv;
    reg_raddr1_i    = r1;
    reg_raddr2_i    = r2;
    dec_reg_write_i = dw;
    dec_reg_addr_i  = da;
    ex_reg_write_i  = ew;
    ex_reg_addr_i   = ea;
    reg_write_i     = rw;
    reg_waddr_i     = wa;
  endtask

  task automatic idle();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Check against the model shortly after inputs settle, then advance one clock.
  task automatic runCycle(input string tag);
    #1;
    checkOutput(tag);
    modelAdvance();
    @(posedge clk_i);
    #1;
  endtask

  // Asynchronous reset pulse placed between clock edges.
  task automatic doReset(input string tag);
    rst_i = 1'b0;
    #1;
    modelReset();
    checkBit({tag, "_rst_discard"}, ex_discard_request_o, 1'b0);
    checkBit({tag, "_rst_err"},     err_o,                1'b0);
    checkOutput({tag, "_rst"});
    rst_i = 1'b1;
    #1;
  endtask

  initial begin
    rst_i = 1'b0;
    idle();
    modelReset();
    @(posedge clk_i);
    #1;
    doReset("init");

    // Idle: a read of x5 with nothing pending must not stall.
    applyStimulus(0, 1, 5, 0, 0, 0, 0, 0, 0, 0);
    #1 checkBit("idle_stall", dec_stall_request_o, 1'b0);
    runCycle("idle");

    // Write to x7 then read it; retire clears the hazard a cycle later.
    applyStimulus(0, 1, 0, 0, 1, 7, 0, 0, 0, 0);
    runCycle("x7_issue");
    applyStimulus(0, 1, 7, 0, 0, 0, 0, 0, 1, 7);
    #1 checkBit("x7_stall", dec_stall_request_o, 1'b1);
    runCycle("x7_retire");
    applyStimulus(0, 1, 7, 0, 0, 0, 0, 0, 0, 0);
    #1 checkBit("x7_cleared", dec_stall_request_o, 1'b0);
    runCycle("x7_read");

    // x0 is never tracked.
    applyStimulus(0, 1, 0, 0, 1, 0, 0, 0, 0, 0);
    runCycle("x0_issue");
    applyStimulus(0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    #1 checkBit("x0_stall", dec_stall_request_o, 1'b0);
    checkBit("x0_err", err_o, 1'b0);
    runCycle("x0_read");

    // Fill x3, check full stall, drain, then underflow sets the sticky error.
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 1, 0, 0, 1, 3, 0, 0, 0, 0);
      runCycle("x3_fill");
    end
    applyStimulus(0, 1, 0, 0, 1, 3, 0, 0, 0, 0);
    #1 checkBit("x3_full_stall", dec_stall_request_o, 1'b1);
    runCycle("x3_full");
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 3);
      runCycle("x3_drain");
    end
    applyStimulus(0, 1, 3, 0, 0, 0, 0, 0, 1, 3);
    #1 checkBit("x3_drained", dec_stall_request_o, 1'b0);
    checkBit("x3_err_before", err_o, 1'b0);
    runCycle("x3_underflow");
    idle();
    #1 checkBit("x3_err_set", err_o, 1'b1);
    for (int i = 0; i < 3; i++) runCycle("x3_sticky");
    checkBit("x3_err_sticky", err_o, 1'b1);
    doReset("x3");

    // Branch kills the execute-stage write to x9; issue blocked for the whole window.
    applyStimulus(0, 1, 0, 0, 1, 9, 0, 0, 0, 0);
    runCycle("br_issue9");
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1 checkBit("br_edge_discard", ex_discard_request_o, 1'b0);
    runCycle("br_edge");
    applyStimulus(0, 1, 9, 0, 1, 10, 1, 9, 0, 0);
    #1 checkBit("br_w1_discard", ex_discard_request_o, 1'b1);
    checkBit("br_w1_stall", dec_stall_request_o, 1'b1);
    runCycle("br_w1");
    applyStimulus(0, 1, 9, 0, 1, 10, 1, 9, 0, 0);
    #1 checkBit("br_w2_discard", ex_discard_request_o, 1'b1);
    checkBit("br_w2_cancelled", dec_stall_request_o, 1'b0);
    runCycle("br_w2");
    applyStimulus(0, 1, 10, 0, 0, 0, 0, 0, 0, 0);
    #1 checkBit("br_end_discard", ex_discard_request_o, 1'b0);
    checkBit("br_blocked_issue", dec_stall_request_o, 1'b0);
    checkBit("br_err", err_o, 1'b0);
    runCycle("br_end");

    // Same-cycle issue and retire on x4, then an extended discard window.
    applyStimulus(0, 1, 0, 0, 1, 4, 0, 0, 0, 0);
    runCycle("x4_issue");
    applyStimulus(0, 1, 0, 0, 1, 4, 0, 0, 1, 4);
    runCycle("x4_both");
    applyStimulus(0, 1, 4, 0, 0, 0, 0, 0, 0, 0);
    #1 checkBit("x4_still_pending", dec_stall_request_o, 1'b1);
    runCycle("x4_read");
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 1, 4);
    runCycle("ext_branch");
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1 checkBit("ext_c1", ex_discard_request_o, 1'b1);
    runCycle("ext_c1");
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1 checkBit("ext_c2", ex_discard_request_o, 1'b1);
    runCycle("ext_c2");
    idle();
    #1 checkBit("ext_c3", ex_discard_request_o, 1'b1);
    runCycle("ext_c3");
    #1 checkBit("ext_c4", ex_discard_request_o, 1'b1);
    runCycle("ext_c4");
    #1 checkBit("ext_done", ex_discard_request_o, 1'b0);
    runCycle("ext_done");

    // Reset in the middle of a discard window with x5 pending.
    applyStimulus(0, 1, 0, 0, 1, 5, 0, 0, 0, 0);
    runCycle("mid_issue");
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    runCycle("mid_branch");
    idle();
    doReset("mid");
    applyStimulus(0, 1, 5, 0, 0, 0, 0, 0, 0, 0);
    #1 checkBit("mid_x5_clear", dec_stall_request_o, 1'b0);
    runCycle("mid_after");

    // Random traffic on a small register window so hazards collide often.
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 59) == 0) doReset("rnd");
      applyStimulus($urandom_range(0, 7) == 0,
                    $urandom_range(0, 3) != 0,
                    5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                    $urandom_range(0, 1) == 1, 5'($urandom_range(0, 7)),
                    $urandom_range(0, 1) == 1, 5'($urandom_range(0, 7)),
                    $urandom_range(0, 2) == 0, 5'($urandom_range(0, 7)));
      runCycle("rnd");
    end

    idle();
    runCycle("final");
    $display("End of test - %0d assertions evaluated, %0d failures", evals, fails);
    $finish;
  end

endmodule
